// File: rtl/axi_4_lite_mst_pkg.sv
// Shared widths, AXI response codes and master FSM encodings for the AXI4-Lite master.
package axi_4_lite_mst_pkg;

  localparam int C_AXI_ADDR_WIDTH   = 32;
  localparam int C_AXI_DATA_WIDTH   = 32;
  localparam int C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    MST_IDLE    = 3'd0,
    MST_WR      = 3'd1,
    MST_WR_RESP = 3'd2,
    MST_RD_ADDR = 3'd3,
    MST_RD_DATA = 3'd4,
    MST_RESP    = 3'd5
  } mst_state_e;

endpackage

// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI transaction,
// one valid/ready response out. Every AXI and handshake output is a flop.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   MST_IDLE    | cmd_ready high, waiting for a command
//   MST_WR      | AW and W offered, each dropped after its own handshake
//   MST_WR_RESP | BREADY high, waiting for BVALID
//   MST_RD_ADDR | ARVALID high, waiting for ARREADY
//   MST_RD_DATA | RREADY high, waiting for RVALID
//   MST_RESP    | rsp_valid high, response held until rsp_ready
module axi_4_lite_mst
  import axi_4_lite_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = C_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_AXI_DATA_WIDTH,
  parameter int STRB_WIDTH = C_AXI_STROBE_WIDTH
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,

  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,

  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  input  logic [1:0]            M_AXI_BRESP,

  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,

  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP
);

  mst_state_e state_q, state_nxt;

  logic                  aw_done_q, aw_done_nxt;
  logic                  w_done_q, w_done_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_nxt;

  logic                  cmd_ready_q, cmd_ready_nxt;
  logic                  aw_valid_q, aw_valid_nxt;
  logic                  w_valid_q, w_valid_nxt;
  logic                  b_ready_q, b_ready_nxt;
  logic                  ar_valid_q, ar_valid_nxt;
  logic                  r_ready_q, r_ready_nxt;

  logic                  rsp_valid_q, rsp_valid_nxt;
  logic                  rsp_write_q, rsp_write_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic [1:0]            rsp_resp_q, rsp_resp_nxt;

  logic                  aw_hs, w_hs;

  assign aw_hs = aw_valid_q & M_AXI_AWREADY;
  assign w_hs  = w_valid_q & M_AXI_WREADY;

  always_comb begin
    state_nxt     = state_q;
    aw_done_nxt   = aw_done_q;
    w_done_nxt    = w_done_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    wstrb_nxt     = wstrb_q;
    rsp_write_nxt = rsp_write_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_resp_nxt  = rsp_resp_q;

    case (state_q)
      MST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_nxt    = cmd_addr;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (cmd_write) begin
            wdata_nxt = cmd_wdata;
            wstrb_nxt = cmd_wstrb;
            state_nxt = MST_WR;
          end else begin
            state_nxt = MST_RD_ADDR;
          end
        end
      end
      MST_WR: begin
        aw_done_nxt = aw_done_q | aw_hs;
        w_done_nxt  = w_done_q | w_hs;
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt = MST_WR_RESP;
        end
      end
      MST_WR_RESP: begin
        if (b_ready_q && M_AXI_BVALID) begin
          rsp_resp_nxt  = M_AXI_BRESP;
          rsp_rdata_nxt = '0;
          rsp_write_nxt = 1'b1;
          state_nxt     = MST_RESP;
        end
      end
      MST_RD_ADDR: begin
        if (ar_valid_q && M_AXI_ARREADY) begin
          state_nxt = MST_RD_DATA;
        end
      end
      MST_RD_DATA: begin
        if (r_ready_q && M_AXI_RVALID) begin
          rsp_resp_nxt  = M_AXI_RRESP;
          rsp_rdata_nxt = M_AXI_RDATA;
          rsp_write_nxt = 1'b0;
          state_nxt     = MST_RESP;
        end
      end
      MST_RESP: begin
        if (rsp_ready) begin
          state_nxt = MST_IDLE;
        end
      end
      default: state_nxt = MST_IDLE;
    endcase

    // Handshake outputs are decoded from the next state so they are registered
    // and never depend combinationally on a READY input.
    cmd_ready_nxt = (state_nxt == MST_IDLE);
    aw_valid_nxt  = (state_nxt == MST_WR) && !aw_done_nxt;
    w_valid_nxt   = (state_nxt == MST_WR) && !w_done_nxt;
    b_ready_nxt   = (state_nxt == MST_WR_RESP);
    ar_valid_nxt  = (state_nxt == MST_RD_ADDR);
    r_ready_nxt   = (state_nxt == MST_RD_DATA);
    rsp_valid_nxt = (state_nxt == MST_RESP);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= MST_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cmd_ready_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_nxt;
      aw_done_q   <= aw_done_nxt;
      w_done_q    <= w_done_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      wstrb_q     <= wstrb_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      aw_valid_q  <= aw_valid_nxt;
      w_valid_q   <= w_valid_nxt;
      b_ready_q   <= b_ready_nxt;
      ar_valid_q  <= ar_valid_nxt;
      r_ready_q   <= r_ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_write_q <= rsp_write_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_resp_q  <= rsp_resp_nxt;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = b_ready_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_RREADY  = r_ready_q;

endmodule
